// File: rtl/knn_vote_pkg.sv
// Shared defaults, widths and FSM encodings for the knn majority-vote stage.
package knn_vote_pkg;

  localparam int DEF_HW_K      = 10;
  localparam int DEF_N_SOLVERS = 10;
  localparam int DEF_N_CLASSES = 16;
  localparam int DEF_LABEL_W   = 8;

  // Index/counter width that never collapses to zero bits.
  function automatic int w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CNT_W = w_of(DEF_HW_K + 1);
  localparam int DEF_K_W   = w_of(DEF_HW_K);
  localparam int DEF_C_W   = w_of(DEF_N_CLASSES);
  localparam int DEF_S_W   = w_of(DEF_N_SOLVERS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_ARGMAX = 3'd3;
  localparam logic [2:0] ST_STORE  = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

endpackage

// File: rtl/knn_vote_if.sv
// Control, knn readout and result-bank signals of the vote stage.
interface knn_vote_if;
  import knn_vote_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   knn_rd;
  logic [15:0]            knn_sel;
  logic [15:0]            knn_solver_sel;
  logic [15:0]            knn_data;
  logic [15:0]            res_sel;
  logic [DEF_LABEL_W-1:0] res_label;
  logic                   res_valid;

  modport master (
    input  start, knn_data, res_sel,
    output busy, done, err, knn_rd, knn_sel, knn_solver_sel, res_label, res_valid
  );

  modport slave (
    output start, knn_data, res_sel,
    input  busy, done, err, knn_rd, knn_sel, knn_solver_sel, res_label, res_valid
  );
endinterface

// File: rtl/knn_vote_hist.sv
// Per-class neighbour counters: clear, count in-range labels, indexed read.
module knn_vote_hist
  import knn_vote_pkg::*;
#(
  parameter int N_CLASSES = DEF_N_CLASSES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LABEL_W   = DEF_LABEL_W,
  parameter int C_W       = DEF_C_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [LABEL_W-1:0] label,
  input  logic [C_W-1:0]     rd_idx,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic               label_bad
);

  localparam logic [LABEL_W-1:0] LABEL_LIM = LABEL_W'(N_CLASSES);

  logic [CNT_W-1:0] cnt [N_CLASSES];
  logic             in_range;

  assign in_range  = label < LABEL_LIM;
  assign label_bad = inc && !in_range;
  assign rd_cnt    = cnt[rd_idx];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
    end else if (inc && in_range) begin
      cnt[label[C_W-1:0]] <= cnt[label[C_W-1:0]] + CNT_W'(1);
    end
  end

endmodule

// File: rtl/knn_vote.sv
// Majority vote over each knn solver's K nearest labels; one result per solver.
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int HW_K      = DEF_HW_K,
  parameter int N_SOLVERS = DEF_N_SOLVERS,
  parameter int N_CLASSES = DEF_N_CLASSES,
  parameter int LABEL_W   = DEF_LABEL_W
) (
  input logic        clk,
  input logic        rst,
  knn_vote_if.master bus
);

  localparam int CNT_W = w_of(HW_K + 1);
  localparam int K_W   = w_of(HW_K);
  localparam int C_W   = w_of(N_CLASSES);
  localparam int S_W   = w_of(N_SOLVERS);

  localparam logic [K_W-1:0] K_LAST  = K_W'(HW_K - 1);
  localparam logic [C_W-1:0] C_LAST  = C_W'(N_CLASSES - 1);
  localparam logic [S_W-1:0] S_LAST  = S_W'(N_SOLVERS - 1);
  localparam logic [15:0]    SEL_LIM = 16'(N_SOLVERS);

  logic [2:0]         state;
  logic [K_W-1:0]     k;
  logic [C_W-1:0]     c;
  logic [S_W-1:0]     s;
  logic [CNT_W-1:0]   best_cnt;
  logic [C_W-1:0]     best_cls;
  logic               err_flag;
  logic               valid_flag;
  logic [LABEL_W-1:0] bank [N_SOLVERS];

  logic [CNT_W-1:0]   hist_cnt;
  logic               label_bad;
  logic               unused_data_hi;

  assign unused_data_hi = ^bus.knn_data[15:LABEL_W];

  knn_vote_hist #(
    .N_CLASSES (N_CLASSES),
    .CNT_W     (CNT_W),
    .LABEL_W   (LABEL_W),
    .C_W       (C_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_CLEAR),
    .inc       (state == ST_SCAN),
    .label     (bus.knn_data[LABEL_W-1:0]),
    .rd_idx    (c),
    .rd_cnt    (hist_cnt),
    .label_bad (label_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      c          <= '0;
      s          <= '0;
      best_cnt   <= '0;
      best_cls   <= '0;
      err_flag   <= 1'b0;
      valid_flag <= 1'b0;
      for (int unsigned i = 0; i < N_SOLVERS; i++) bank[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_CLEAR;
            s          <= '0;
            err_flag   <= 1'b0;
            valid_flag <= 1'b0;
          end
        end
        ST_CLEAR: begin
          k        <= '0;
          best_cnt <= '0;
          best_cls <= '0;
          state    <= ST_SCAN;
        end
        ST_SCAN: begin
          if (label_bad) err_flag <= 1'b1;
          if (k == K_LAST) begin
            k     <= '0;
            c     <= '0;
            state <= ST_ARGMAX;
          end else begin
            k <= k + K_W'(1);
          end
        end
        ST_ARGMAX: begin
          // Strict compare keeps the earliest (lowest) class on ties.
          if (hist_cnt > best_cnt) begin
            best_cnt <= hist_cnt;
            best_cls <= c;
          end
          if (c == C_LAST) begin
            c     <= '0;
            state <= ST_STORE;
          end else begin
            c <= c + C_W'(1);
          end
        end
        ST_STORE: begin
          bank[s] <= LABEL_W'(best_cls);
          if (s == S_LAST) begin
            state <= ST_FIN;
          end else begin
            s     <= s + S_W'(1);
            state <= ST_CLEAR;
          end
        end
        ST_FIN: begin
          valid_flag <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_FIN);
  assign bus.knn_rd         = (state == ST_SCAN);
  assign bus.knn_sel        = 16'(k);
  assign bus.knn_solver_sel = 16'(s);
  assign bus.err            = err_flag;
  assign bus.res_valid      = valid_flag;

  always_comb begin
    bus.res_label = '0;
    if (bus.res_sel < SEL_LIM) bus.res_label = bank[bus.res_sel[S_W-1:0]];
  end

endmodule

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: behavioural knn label source, per-cycle readout checks, result scoreboard.
module tb_knn_vote;

  localparam int PASS_CYC = 281;

  typedef struct packed {
    logic [9:0][7:0] lab;
    logic [7:0]      exp_label;
    logic            bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic [7:0] cur_lab [10][10];
  logic [7:0] exp_q [$];
  vec_t       vt [10];

  knn_vote_if bus ();

  knn_vote #(
    .HW_K      (10),
    .N_SOLVERS (10),
    .N_CLASSES (16),
    .LABEL_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // knn readout model: upper data bits carry junk the DUT must ignore.
  always_comb begin
    bus.knn_data = 16'hFFFF;
    if (bus.knn_sel < 16'd10 && bus.knn_solver_sel < 16'd10)
      bus.knn_data = {8'hA5, cur_lab[bus.knn_solver_sel[3:0]][bus.knn_sel[3:0]]};
  end

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9,
                              input int e, input bit b);
    vec_t r;
    r.lab[0] = 8'(a0); r.lab[1] = 8'(a1); r.lab[2] = 8'(a2); r.lab[3] = 8'(a3);
    r.lab[4] = 8'(a4); r.lab[5] = 8'(a5); r.lab[6] = 8'(a6); r.lab[7] = 8'(a7);
    r.lab[8] = 8'(a8); r.lab[9] = 8'(a9);
    r.exp_label = 8'(e);
    r.bad = b;
    return r;
  endfunction

  task automatic load_uniform(input int lbl);
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 10; k++) cur_lab[s][k] = 8'(lbl);
      exp_q.push_back(8'(lbl));
    end
  endtask

  task automatic load_table(output bit any_bad);
    any_bad = 1'b0;
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 10; k++) cur_lab[s][k] = vt[s].lab[k];
      exp_q.push_back(vt[s].exp_label);
      any_bad |= vt[s].bad;
    end
  endtask

  // Drives one full pass and checks the readout walk cycle by cycle; cycle 1 follows the start edge.
  task automatic run_pass(input bit extra_start, input bit exp_err);
    int ph, sv;
    bit rd;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= PASS_CYC; cyc++) begin
      ph = (cyc - 1) % 28;
      sv = (cyc - 1) / 28;
      rd = (cyc <= 280) && (ph >= 1) && (ph <= 10);
      check($sformatf("busy c%0d", cyc), int'(bus.busy), 1);
      check($sformatf("done c%0d", cyc), int'(bus.done), int'(cyc == PASS_CYC));
      check($sformatf("knn_rd c%0d", cyc), int'(bus.knn_rd), int'(rd));
      if (rd) begin
        check($sformatf("knn_sel c%0d", cyc), int'(bus.knn_sel), ph - 1);
        check($sformatf("solver_sel c%0d", cyc), int'(bus.knn_solver_sel), sv);
      end
      if (cyc == 1) begin
        check("res_valid cleared", int'(bus.res_valid), 0);
        check("err cleared", int'(bus.err), 0);
      end
      if (cyc == PASS_CYC) check("err at done", int'(bus.err), int'(exp_err));
      bus.start = extra_start && (cyc == 50 || cyc == PASS_CYC);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("busy after fin", int'(bus.busy), 0);
    check("done after fin", int'(bus.done), 0);
    check("res_valid after fin", int'(bus.res_valid), 1);
    check("err held", int'(bus.err), int'(exp_err));
    for (int s = 0; s < 10; s++) begin
      bus.res_sel = 16'(s);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("scoreboard empty s%0d", s), 1, 0);
      end else begin
        check($sformatf("res_label s%0d", s), int'(bus.res_label), int'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic reset_mid_scan();
    bit dummy;
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 10; k++) cur_lab[s][k] = vt[s].lab[k];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 118; cyc++) begin
      @(posedge clk); #1;
    end
    check("mid rd", int'(bus.knn_rd), 1);
    check("mid solver", int'(bus.knn_solver_sel), 4);
    check("mid sel", int'(bus.knn_sel), 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst err", int'(bus.err), 0);
    check("rst res_valid", int'(bus.res_valid), 0);
    check("rst knn_rd", int'(bus.knn_rd), 0);
    check("rst knn_sel", int'(bus.knn_sel), 0);
    check("rst solver_sel", int'(bus.knn_solver_sel), 0);
    for (int s = 0; s < 10; s++) begin
      bus.res_sel = 16'(s);
      #1;
      check($sformatf("rst bank s%0d", s), int'(bus.res_label), 0);
    end
    dummy = 1'b0;
  endtask

  initial begin
    bit tbl_bad;
    vt[0] = mk(1, 1, 2, 2, 2, 5, 5, 5, 5, 0, 5, 0);
    vt[1] = mk(4, 4, 4, 7, 7, 7, 0, 0, 1, 1, 4, 0);
    vt[2] = mk(200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 0, 1);
    vt[3] = mk(15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 0);
    vt[4] = mk(0, 0, 9, 9, 9, 0, 3, 3, 3, 3, 3, 0);
    vt[5] = mk(14, 13, 14, 13, 12, 12, 12, 13, 14, 11, 12, 0);
    vt[6] = mk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0);
    vt[7] = mk(10, 10, 11, 11, 12, 12, 13, 13, 14, 14, 10, 0);
    vt[8] = mk(6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 0);
    vt[9] = mk(2, 9, 9, 2, 9, 2, 9, 2, 9, 8, 9, 0);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.res_sel = '0;
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 10; k++) cur_lab[s][k] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err", int'(bus.err), 0);
    check("reset knn_rd", int'(bus.knn_rd), 0);
    check("reset knn_sel", int'(bus.knn_sel), 0);
    check("reset solver_sel", int'(bus.knn_solver_sel), 0);
    check("reset res_valid", int'(bus.res_valid), 0);
    check("reset res_label", int'(bus.res_label), 0);

    load_uniform(3);
    run_pass(1'b1, 1'b0);

    bus.res_sel = 16'd12; #1;
    check("res_sel 12", int'(bus.res_label), 0);
    bus.res_sel = 16'd10; #1;
    check("res_sel 10", int'(bus.res_label), 0);
    bus.res_sel = 16'hFFFF; #1;
    check("res_sel ffff", int'(bus.res_label), 0);

    load_table(tbl_bad);
    run_pass(1'b0, tbl_bad);

    reset_mid_scan();

    load_table(tbl_bad);
    run_pass(1'b0, tbl_bad);

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
